// File: rtl/port_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// port_mailbox_pkg
// Shared definitions for the CPU port mailbox bridge.
//   - Bit positions inside the CPU port_out (cpu_out) and port_in (cpu_in)
//     words.
//   - byte_t: the 8-bit payload type carried on both streams.
// No ports (package).
// ---------------------------------------------------------------------------
package port_mailbox_pkg;

  // cpu_out fields (written by the CPU)
  localparam int TX_BYTE_LSB = 0;
  localparam int TX_REQ_BIT  = 8;
  localparam int RX_ACK_BIT  = 9;

  // cpu_in fields (read by the CPU)
  localparam int RX_BYTE_LSB = 0;
  localparam int TX_ACK_BIT  = 8;
  localparam int RX_REQ_BIT  = 9;
  localparam int TX_FULL_BIT = 10;
  localparam int RX_PEND_BIT = 11;
  localparam int COUNT_LSB   = 12;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/port_mailbox_if.sv
// ---------------------------------------------------------------------------
// port_mailbox_if
// Bundles the CPU port banks and both byte streams of the mailbox.
//   cpu_out  [31:0] CPU port_out bank  (toward mailbox)
//   cpu_in   [31:0] CPU port_in bank   (from mailbox)
//   tx_data/tx_valid/tx_ready : downstream byte stream (mailbox is source)
//   rx_data/rx_valid/rx_ready : upstream byte stream (mailbox is sink)
// Modports:
//   slave  - the mailbox itself
//   master - the surroundings (CPU + stream partners, or a testbench)
// ---------------------------------------------------------------------------
interface port_mailbox_if;
  import port_mailbox_pkg::*;

  logic [31:0] cpu_out;
  logic [31:0] cpu_in;
  byte_t       tx_data;
  logic        tx_valid;
  logic        tx_ready;
  byte_t       rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  cpu_out, tx_ready, rx_data, rx_valid,
    output cpu_in, tx_data, tx_valid, rx_ready
  );

  modport master (
    output cpu_out, tx_ready, rx_data, rx_valid,
    input  cpu_in, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/port_mailbox_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO, DEPTH entries (power of two, 2..8), no fall-through:
// a byte pushed at edge N is first visible on dout_o after edge N.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   push_i   in   write din_i (ignored while full)
//   din_i    in   byte to write
//   pop_i    in   advance the read side (ignored while empty)
//   dout_o   out  head entry
//   count_o  out  occupancy, 0..DEPTH
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
// full_o/empty_o come from the registered count, so a push into a full FIFO
// is refused even when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module byte_fifo
  import port_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  byte_t      din_i,
  input  logic       pop_i,
  output byte_t      dout_o,
  output logic [3:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  byte_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]     count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == 4'd0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head never shows stale or unknown data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/port_mailbox.sv
// ---------------------------------------------------------------------------
// port_mailbox
// Bridge between the CPU's 32-bit port banks and two byte streams, using
// toggle handshakes because the CPU writes one nibble per instruction.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   bus   port_mailbox_if.slave
//     cpu_out [7:0] tx byte, [8] tx_req toggle, [9] rx_ack toggle
//     cpu_in  [7:0] rx byte, [8] tx_ack toggle, [9] rx_req toggle,
//             [10] tx full, [11] rx pending, [15:12] tx count, [31:16] zero
//     tx_*    downstream stream fed by the TX FIFO
//     rx_*    upstream stream captured into a single holding register
// Parameter: DEPTH - TX FIFO entries, power of two, 2..8.
// Build option: PORT_MAILBOX_STATUS_EN exposes cpu_in[15:10]; without it
// those bits read 0 and only the toggles are visible to software.
// ---------------------------------------------------------------------------
module port_mailbox
  import port_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  port_mailbox_if.slave bus
);

  logic        tx_tog_q, tx_tog_d;
  logic        rx_tog_q, rx_tog_d;
  logic        rx_full_q, rx_full_d;
  byte_t       rx_hold_q, rx_hold_d;

  logic        tx_pending;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [3:0]  tx_count;
  logic        rx_accept;
  logic        rx_release;

  // A TX request is outstanding while the CPU's toggle differs from ours; it
  // simply waits (no drop) until the FIFO has room.
  assign tx_pending = (bus.cpu_out[TX_REQ_BIT] != tx_tog_q);
  assign tx_push    = tx_pending && !tx_full;
  assign tx_pop     = bus.tx_valid && bus.tx_ready;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (bus.cpu_out[TX_BYTE_LSB +: 8]),
    .pop_i   (tx_pop),
    .dout_o  (bus.tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign bus.tx_valid = !tx_empty;

  // rx_ready gated by rst so an in-flight upstream beat is never acknowledged
  // while the block is held in reset.
  assign bus.rx_ready = rst && !rx_full_q;
  assign rx_accept    = bus.rx_valid && bus.rx_ready;
  // The CPU releases the holding register by echoing our rx toggle; accept
  // and release cannot coincide because accept requires rx_full_q == 0.
  assign rx_release   = rx_full_q && (bus.cpu_out[RX_ACK_BIT] == rx_tog_q);

  always_comb begin
    tx_tog_d  = tx_tog_q;
    rx_tog_d  = rx_tog_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    if (tx_push) tx_tog_d = bus.cpu_out[TX_REQ_BIT];
    if (rx_accept) begin
      rx_hold_d = bus.rx_data;
      rx_full_d = 1'b1;
      rx_tog_d  = !rx_tog_q;
    end else if (rx_release) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_tog_q  <= 1'b0;
      rx_tog_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
    end else begin
      tx_tog_q  <= tx_tog_d;
      rx_tog_q  <= rx_tog_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
    end
  end

  // Every cpu_in bit is taken from a register, so there is no combinational
  // path from cpu_out back to cpu_in.
  always_comb begin
    bus.cpu_in                       = '0;
    bus.cpu_in[RX_BYTE_LSB +: 8]     = rx_hold_q;
    bus.cpu_in[TX_ACK_BIT]           = tx_tog_q;
    bus.cpu_in[RX_REQ_BIT]           = rx_tog_q;
`ifdef PORT_MAILBOX_STATUS_EN
    bus.cpu_in[TX_FULL_BIT]          = tx_full;
    bus.cpu_in[RX_PEND_BIT]          = rx_full_q;
    bus.cpu_in[COUNT_LSB +: 4]       = tx_count;
`endif
  end

`ifndef PORT_MAILBOX_STATUS_EN
  // The FIFO still keeps its count internally; it just is not reported.
  logic unused_count;
  assign unused_count = ^tx_count;
`endif

  logic unused_cpu_out;
  assign unused_cpu_out = ^bus.cpu_out[31:10];

endmodule

// File: tb/tb_port_mailbox.sv
// ---------------------------------------------------------------------------
// tb_port_mailbox
// Directed bench for port_mailbox (DEPTH = 8): a vector table for the basic
// TX/RX handshakes, then hand-written sequences for FIFO full/stall, sustained
// streaming with pointer wrap, and asynchronous reset mid-operation.
// Status bits are only expected when PORT_MAILBOX_STATUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_port_mailbox;
  import port_mailbox_pkg::*;

`ifdef PORT_MAILBOX_STATUS_EN
  localparam logic [31:0] STATUS_MASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] STATUS_MASK = 32'h0000_03FF;
`endif

  typedef struct {
    logic [31:0] cpuOut;
    logic        txReady;
    logic        rxValid;
    logic [7:0]  rxData;
    logic [31:0] expCpuIn;
    logic        expTxValid;
    logic [7:0]  expTxData;
    logic        expRxReady;
  } vec_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  logic expTog;
  vec_t vecs [9];

  port_mailbox_if mbx ();

  port_mailbox #(
    .DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mbx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    mbx.cpu_out  = v.cpuOut;
    mbx.tx_ready = v.txReady;
    mbx.rx_valid = v.rxValid;
    mbx.rx_data  = v.rxData;
  endtask

  // Flip the TX toggle with a new byte and wait (bounded) for the ack.
  task automatic pushByte(input logic [7:0] data);
    int n;
    expTog = !expTog;
    mbx.cpu_out = {22'b0, 1'b0, expTog, data};
    n = 0;
    do begin
      tick();
      n++;
    end while (mbx.cpu_in[8] !== expTog && n < 20);
    checkOutput("pushAck", {31'b0, mbx.cpu_in[8]}, {31'b0, expTog});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    expTog     = 1'b0;

    //          cpuOut        rdy  rxV  rxD    expCpuIn      txV  txD    rxRdy
    vecs[0] = '{32'h000,      0,   0,   8'h00, 32'h0000_0000, 0,  8'h00, 1};
    vecs[1] = '{32'h0A5,      0,   0,   8'h00, 32'h0000_0000, 0,  8'h00, 1};
    vecs[2] = '{32'h1A5,      1,   0,   8'h00, 32'h0000_1100, 1,  8'hA5, 1};
    vecs[3] = '{32'h1A5,      1,   0,   8'h00, 32'h0000_0100, 0,  8'h00, 1};
    vecs[4] = '{32'h1A5,      1,   1,   8'h3C, 32'h0000_0B3C, 0,  8'h00, 0};
    vecs[5] = '{32'h1A5,      1,   1,   8'h55, 32'h0000_0B3C, 0,  8'h00, 0};
    vecs[6] = '{32'h3A5,      1,   1,   8'h55, 32'h0000_033C, 0,  8'h00, 1};
    vecs[7] = '{32'h3A5,      1,   1,   8'h55, 32'h0000_0955, 0,  8'h00, 0};
    vecs[8] = '{32'h1A5,      1,   0,   8'h00, 32'h0000_0155, 0,  8'h00, 1};

    mbx.cpu_out  = '0;
    mbx.tx_ready = 1'b0;
    mbx.rx_valid = 1'b0;
    mbx.rx_data  = '0;
    rst = 1'b0;
    #12;
    checkOutput("resetCpuIn", mbx.cpu_in, 32'h0);
    checkOutput("resetTxValid", {31'b0, mbx.tx_valid}, 32'h0);
    checkOutput("resetRxReady", {31'b0, mbx.rx_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idleCpuIn", mbx.cpu_in, 32'h0);
    checkOutput("idleTxValid", {31'b0, mbx.tx_valid}, 32'h0);
    checkOutput("idleRxReady", {31'b0, mbx.rx_ready}, 32'h1);

    // Table: single TX byte, then RX capture / hold-off / release / re-accept.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d.cpuIn", i), mbx.cpu_in, vecs[i].expCpuIn & STATUS_MASK);
      checkOutput($sformatf("vec%0d.txValid", i), {31'b0, mbx.tx_valid}, {31'b0, vecs[i].expTxValid});
      if (vecs[i].expTxValid)
        checkOutput($sformatf("vec%0d.txData", i), {24'b0, mbx.tx_data}, {24'b0, vecs[i].expTxData});
      checkOutput($sformatf("vec%0d.rxReady", i), {31'b0, mbx.rx_ready}, {31'b0, vecs[i].expRxReady});
    end
    mbx.rx_valid = 1'b0;
    expTog = 1'b1;

    // Fill the FIFO, stall a ninth request, then drain in order.
    mbx.tx_ready = 1'b0;
    for (int k = 1; k <= 8; k++) pushByte(8'(k));
    checkOutput("fullCpuIn", mbx.cpu_in, 32'h0000_8555 & STATUS_MASK);
    checkOutput("fullHead", {24'b0, mbx.tx_data}, 32'h01);
    mbx.cpu_out = {22'b0, 1'b0, 1'b0, 8'h09};
    tick(); tick(); tick();
    checkOutput("stallCpuIn", mbx.cpu_in, 32'h0000_8555 & STATUS_MASK);
    mbx.tx_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      checkOutput($sformatf("drainValid%0d", k), {31'b0, mbx.tx_valid}, 32'h1);
      checkOutput($sformatf("drainData%0d", k), {24'b0, mbx.tx_data}, 32'(k));
      tick();
      if (k == 1) checkOutput("stallAckHeld", {31'b0, mbx.cpu_in[8]}, 32'h1);
      if (k == 2) checkOutput("stallAckDone", {31'b0, mbx.cpu_in[8]}, 32'h0);
    end
    expTog = 1'b0;
    checkOutput("drainEmpty", {31'b0, mbx.tx_valid}, 32'h0);
    checkOutput("drainCpuIn", mbx.cpu_in, 32'h0000_0055 & STATUS_MASK);

    // Sustained streaming: one toggle every 2 cycles, pointers wrap twice.
    for (int i = 0; i < 20; i++) begin
      expTog = !expTog;
      mbx.cpu_out = {22'b0, 1'b0, expTog, 8'(8'h20 + i)};
      tick();
      checkOutput($sformatf("streamValid%0d", i), {31'b0, mbx.tx_valid}, 32'h1);
      checkOutput($sformatf("streamData%0d", i), {24'b0, mbx.tx_data}, 32'(8'h20 + i));
      checkOutput($sformatf("streamAck%0d", i), {31'b0, mbx.cpu_in[8]}, {31'b0, expTog});
      tick();
      checkOutput($sformatf("streamPopped%0d", i), {31'b0, mbx.tx_valid}, 32'h0);
    end

    // Reset mid-operation with three queued bytes and a held RX byte.
    mbx.tx_ready = 1'b0;
    pushByte(8'h61);
    pushByte(8'h62);
    pushByte(8'h63);
    mbx.rx_valid = 1'b1;
    mbx.rx_data  = 8'h77;
    tick();
    mbx.rx_valid = 1'b0;
    checkOutput("preResetCpuIn", mbx.cpu_in, 32'h0000_3B77 & STATUS_MASK);
    #3;
    rst = 1'b0;
    mbx.cpu_out  = '0;
    mbx.rx_valid = 1'b1;
    mbx.rx_data  = 8'h99;
    #1;
    checkOutput("asyncCpuIn", mbx.cpu_in, 32'h0);
    checkOutput("asyncTxValid", {31'b0, mbx.tx_valid}, 32'h0);
    checkOutput("asyncRxReady", {31'b0, mbx.rx_ready}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    mbx.rx_valid = 1'b0;
    rst = 1'b1;
    expTog = 1'b0;
    tick();
    checkOutput("postResetCpuIn", mbx.cpu_in, 32'h0);
    checkOutput("postResetRxReady", {31'b0, mbx.rx_ready}, 32'h1);
    mbx.tx_ready = 1'b1;
    tick(); tick(); tick();
    checkOutput("postResetTxValid", {31'b0, mbx.tx_valid}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/port_mailbox.md
Name: port_mailbox

Overview:
Mailbox bridge on the CPU's 32-bit I/O ports. It consumes the CPU's port_out register bank and drives the CPU's port_in bank. Software exchanges bytes with two valid/ready streams using toggle handshakes.
- TX: bytes written by the CPU go into a FIFO that drains onto a downstream stream.
- RX: bytes from an upstream stream are held in a single register for the CPU to read.
The CPU writes one nibble per instruction, so toggles live in a nibble written after the data nibbles.

Parameters:
DEPTH, 8, TX FIFO entries; power of two, 2..8 (count fits 4 bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
cpu_out  input  32  from CPU port_out; [7:0] tx byte, [8] tx_req toggle, [9] rx_ack toggle, [31:10] ignored
cpu_in  output  32  to CPU port_in; [7:0] rx byte, [8] tx_ack toggle, [9] rx_req toggle, [10] tx full, [11] rx pending, [15:12] tx count, [31:16] zero
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  downstream accepts
rx_data  input  8  upstream byte
rx_valid  input  1  upstream byte present
rx_ready  output  1  holding register free

Behaviour:
- Reset (rst low, async): FIFO empty, pointers 0, count 0, tx_tog 0, rx_tog 0, rx_full 0, rx_hold 0.
  - Hence cpu_in = 0 and tx_valid = 0.
  - rx_ready is forced 0 while rst is low.
- CPU and block must leave reset together: toggles restart at 0 on both sides. A mismatched toggle after release is treated as a real request.
- TX push:
  - Request pending when cpu_out[8] != tx_tog.
  - Pending and count < DEPTH: write cpu_out[7:0] at wr_ptr, wr_ptr++, count++, tx_tog <= cpu_out[8].
  - tx_ack (cpu_in[8]) equals the new tx_tog the cycle after the push.
- TX full:
  - Full uses the registered count.
  - A pending request with count == DEPTH stalls: no push, tx_tog unchanged, no byte dropped. It completes on the first cycle count < DEPTH.
  - A push is blocked when full even if a pop happens in the same cycle.
- TX pop:
  - tx_valid = (count != 0); tx_data = mem[rd_ptr], stable while tx_valid && !tx_ready.
  - On tx_valid && tx_ready: rd_ptr++, count--.
  - Simultaneous push and pop: count unchanged.
  - No fall-through: a byte pushed at edge N is first valid after edge N.
- Pointers are log2(DEPTH) bits and wrap naturally.
- RX:
  - rx_ready = !rx_full (when rst is high).
  - On rx_valid && rx_ready: rx_hold <= rx_data, rx_full <= 1, rx_tog flips.
  - The CPU reads cpu_in[7:0], then writes cpu_out[9] = rx_tog. On any cycle with rx_full && cpu_out[9] == rx_tog, rx_full <= 0; new data is accepted from the next cycle.
  - rx_hold retains its value after release.
- cpu_in[10] = (count == DEPTH); [11] = rx_full; [15:12] = count zero-extended. All cpu_in bits are driven from registers: no combinational path from cpu_out to cpu_in.
- Reset mid-operation discards FIFO contents and any held RX byte. The in-flight stream beat is not acknowledged.

Optional Feature:
PORT_MAILBOX_STATUS_EN
- Defined: cpu_in[10], [11], [15:12] as above.
- Undefined: those bits read 0. Software relies only on the toggles; the count/full logic feeding cpu_in is removed, but the FIFO still uses its internal count.

Decomposition:
- Package port_mailbox_pkg: bit-position constants (TX_BYTE_LSB=0, TX_REQ_BIT=8, RX_ACK_BIT=9, TX_FULL_BIT=10, RX_PEND_BIT=11, COUNT_LSB=12) and a byte_t typedef (8-bit).
- One sub-module: byte_fifo (DEPTH-parameterised synchronous FIFO with push/pop/count/full/empty, async active-low reset). The toggle, RX and cpu_in logic stay in the top.

Test Plan:
- Reset, then cpu_out=0x000 idle 5 cycles -> cpu_in=0, tx_valid=0, rx_ready=1.
- cpu_out=0x0A5, then 0x1A5, tx_ready=1 -> tx_data=0xA5 valid exactly one beat; cpu_in[8]=1 one cycle after the toggle.
- tx_ready=0, push 0x01..0x08 via 8 toggles -> cpu_in[10]=1, count=8. A 9th toggle with 0x09 stalls with cpu_in[8] unchanged. Raise tx_ready -> outputs 0x01..0x09 in order, then the 9th ack appears.
- Sustained push and pop with tx_ready=1 and one toggle every 2 cycles over 20 bytes -> no loss, order preserved, pointer wrap exercised.
- rx_valid with rx_data=0x3C -> cpu_in[7:0]=0x3C, cpu_in[9]=1, rx_ready=0. A second byte 0x55 is held off until cpu_out[9]=1, then accepted next cycle.
- Assert rst with 3 bytes queued and rx_full=1 -> cpu_in=0, tx_valid=0 immediately (async). After release the queued bytes are gone.
